// File: rtl/vtage_pkg.sv
// Shared types and default widths for the VTAGE predictor and its
// feedback path. The predictor and the feedback generator must agree on
// the layout of a prediction bundle, so that layout lives here.
package vtage_pkg;

    localparam int VTAGE_NUM_PRED    = 2;
    localparam int VTAGE_NUM_ENTRIES = 256;
    localparam int VTAGE_NUM_BANK    = 4;
    localparam int VTAGE_CONF_WIDTH  = 8;
    localparam int VTAGE_TAG_WIDTH   = 5;
    localparam int VTAGE_U_WIDTH     = 2;
    localparam int VTAGE_DEPTH       = 16;

    // Table index width follows the number of predictor entries.
    localparam int LP_INDEX_WIDTH = $clog2(VTAGE_NUM_ENTRIES);

    // One captured prediction: the predicted value plus everything the
    // predictor needs to locate and update the providing entry.
    typedef struct packed {
        logic [31:0]                 result;
        logic [VTAGE_CONF_WIDTH:0]   conf;
        logic [LP_INDEX_WIDTH-1:0]   index;
        logic [VTAGE_TAG_WIDTH-1:0]  tag;
        logic [VTAGE_U_WIDTH-1:0]    useful;
        logic [VTAGE_NUM_BANK-1:0]   bank;
    } vtage_pred_meta_t;

    // One feedback way sent back to the predictor.
    typedef struct packed {
        logic [31:0]                 actual;
        logic [VTAGE_CONF_WIDTH:0]   conf;
        logic [LP_INDEX_WIDTH-1:0]   index;
        logic [VTAGE_TAG_WIDTH-1:0]  tag;
        logic [VTAGE_U_WIDTH-1:0]    useful;
        logic [VTAGE_NUM_BANK-1:0]   bank;
        logic                        mispredict;
    } vtage_fb_t;

    // Number of set bits in a two-way qualifier.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/vtage_fb_fifo.sv
// In-order two-write / two-read queue of captured predictions. Valid write
// ways are packed in way order, so a way1-only write lands in the next free
// slot and the queue never contains holes.
module vtage_fb_fifo
    import vtage_pkg::*;
#(
    parameter  int P_DEPTH   = 16,
    localparam int LP_PTR_W  = $clog2(P_DEPTH),
    localparam int LP_CNT_W  = LP_PTR_W + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [1:0]                  wr_en,
    input  vtage_pred_meta_t [1:0]      wr_data,
    input  logic [1:0]                  rd_num,
    output vtage_pred_meta_t [1:0]      rd_data,
    output logic [LP_CNT_W-1:0]         count
);

    vtage_pred_meta_t          mem [P_DEPTH];
    logic [LP_PTR_W-1:0]       wr_ptr;
    logic [LP_PTR_W-1:0]       rd_ptr;
    logic [LP_PTR_W-1:0]       wr_ptr_p1;
    logic [LP_PTR_W-1:0]       rd_ptr_p1;
    logic [1:0]                nalloc;

    assign wr_ptr_p1 = wr_ptr + LP_PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr + LP_PTR_W'(1);
    assign nalloc    = popcount2(wr_en);

    // The two oldest entries are always presented to the retire logic.
    assign rd_data[0] = mem[rd_ptr];
    assign rd_data[1] = mem[rd_ptr_p1];

    // Storage write; a lone way1 write is compressed into the first free slot.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            case (wr_en)
                2'b11: begin
                    mem[wr_ptr]    <= wr_data[0];
                    mem[wr_ptr_p1] <= wr_data[1];
                end
                2'b01:   mem[wr_ptr] <= wr_data[0];
                2'b10:   mem[wr_ptr] <= wr_data[1];
                default: ;
            endcase
        end
    end

    // Pointers and occupancy; a flush returns the queue to its reset state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + LP_PTR_W'(nalloc);
            rd_ptr <= rd_ptr + LP_PTR_W'(rd_num);
            count  <= count + LP_CNT_W'(nalloc) - LP_CNT_W'(rd_num);
        end
    end

endmodule

// File: rtl/vtage_fb_gen.sv
// VTAGE feedback generator. Queues prediction bundles in program order,
// pairs the oldest entries with execution results, and returns registered
// feedback (actual value, stored metadata, mispredict flag) to the predictor.
module vtage_fb_gen
    import vtage_pkg::*;
#(
    parameter  int P_NUM_PRED     = VTAGE_NUM_PRED,
    parameter  int P_NUM_ENTRIES  = VTAGE_NUM_ENTRIES,
    parameter  int P_NUM_BANK     = VTAGE_NUM_BANK,
    parameter  int P_CONF_WIDTH   = VTAGE_CONF_WIDTH,
    parameter  int P_TAG_WIDTH    = VTAGE_TAG_WIDTH,
    parameter  int P_U_WIDTH      = VTAGE_U_WIDTH,
    parameter  int P_DEPTH        = VTAGE_DEPTH,
    localparam int LP_IDX_W       = $clog2(P_NUM_ENTRIES),
    localparam int LP_CW          = P_CONF_WIDTH + 1,
    localparam int LP_CNT_W       = $clog2(P_DEPTH) + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [P_NUM_PRED*32-1:0]           pred_result_i,
    input  logic [P_NUM_PRED*LP_CW-1:0]        pred_conf_i,
    input  logic [P_NUM_PRED*LP_IDX_W-1:0]     pred_index_i,
    input  logic [P_NUM_PRED*P_TAG_WIDTH-1:0]  pred_tag_i,
    input  logic [P_NUM_PRED*P_U_WIDTH-1:0]    pred_useful_i,
    input  logic [P_NUM_PRED*P_NUM_BANK-1:0]   pred_bank_i,
    input  logic [P_NUM_PRED-1:0]              pred_valid_i,
    output logic                               pred_ready_o,
    input  logic [P_NUM_PRED*32-1:0]           ex_actual_i,
    input  logic [P_NUM_PRED-1:0]              ex_valid_i,
    input  logic                               flush_i,
    output logic [P_NUM_PRED*32-1:0]           fb_actual_o,
    output logic [P_NUM_PRED*LP_CW-1:0]        fb_conf_o,
    output logic [P_NUM_PRED*LP_IDX_W-1:0]     fb_index_o,
    output logic [P_NUM_PRED*P_TAG_WIDTH-1:0]  fb_tag_o,
    output logic [P_NUM_PRED*P_U_WIDTH-1:0]    fb_useful_o,
    output logic [P_NUM_PRED*P_NUM_BANK-1:0]   fb_bank_o,
    output logic [P_NUM_PRED-1:0]              fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]              fb_valid_o,
    output logic [LP_CNT_W-1:0]                count_o,
    output logic [1:0]                         err_o
);

    // Highest occupancy that still leaves room for a full-width allocation.
    localparam logic [LP_CNT_W-1:0] LP_READY_LIMIT = LP_CNT_W'(P_DEPTH - P_NUM_PRED);

    logic [LP_CNT_W-1:0]         count;
    vtage_pred_meta_t [1:0]      wr_data;
    vtage_pred_meta_t [1:0]      rd_data;
    logic [1:0]                  wr_en;
    logic [1:0]                  rd_num;
    logic [1:0]                  nret_req;
    logic [1:0]                  nret;
    logic [1:0]                  ret_way;
    logic                        seq_err;
    logic                        underflow;
    logic                        overflow;
    vtage_fb_t [1:0]             fb_d;
    vtage_fb_t [1:0]             fb_q;
    logic [1:0]                  fb_valid_q;
    logic [1:0]                  err_q;

    assign pred_ready_o = (count <= LP_READY_LIMIT);
    assign count_o      = count;

    vtage_fb_fifo #(
        .P_DEPTH (P_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_num  (rd_num),
        .rd_data (rd_data),
        .count   (count)
    );

    // Unpack the incoming bundle and gate allocation on space and flush.
    always_comb begin
        wr_data  = '0;
        for (int w = 0; w < 2; w++) begin
            wr_data[w].result = pred_result_i[w*32 +: 32];
            wr_data[w].conf   = pred_conf_i[w*LP_CW +: LP_CW];
            wr_data[w].index  = pred_index_i[w*LP_IDX_W +: LP_IDX_W];
            wr_data[w].tag    = pred_tag_i[w*P_TAG_WIDTH +: P_TAG_WIDTH];
            wr_data[w].useful = pred_useful_i[w*P_U_WIDTH +: P_U_WIDTH];
            wr_data[w].bank   = pred_bank_i[w*P_NUM_BANK +: P_NUM_BANK];
        end
        overflow = (|pred_valid_i) && !pred_ready_o;
        wr_en    = (flush_i || !pred_ready_o) ? 2'b00 : pred_valid_i;
    end

    // Decide how many entries retire, clamped to what was queued at cycle start.
    always_comb begin
        nret_req = 2'd0;
        seq_err  = 1'b0;
        case (ex_valid_i)
            2'b01:   nret_req = 2'd1;
            2'b11:   nret_req = 2'd2;
            2'b10:   seq_err  = 1'b1;
            default: nret_req = 2'd0;
        endcase
        underflow = (LP_CNT_W'(nret_req) > count);
        nret      = underflow ? count[1:0] : nret_req;
        rd_num    = flush_i ? 2'd0 : nret;
        ret_way   = 2'b00;
        if (!flush_i) begin
            ret_way[0] = (nret != 2'd0);
            ret_way[1] = (nret == 2'd2);
        end
    end

    // Build the feedback word for each way from the result and the stored entry.
    always_comb begin
        fb_d = '0;
        for (int w = 0; w < 2; w++) begin
            fb_d[w].actual     = ex_actual_i[w*32 +: 32];
            fb_d[w].conf       = rd_data[w].conf;
            fb_d[w].index      = rd_data[w].index;
            fb_d[w].tag        = rd_data[w].tag;
            fb_d[w].useful     = rd_data[w].useful;
            fb_d[w].bank       = rd_data[w].bank;
            fb_d[w].mispredict = (ex_actual_i[w*32 +: 32] != rd_data[w].result);
        end
    end

    // Feedback registers hold their contents on idle ways; errors are sticky.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fb_q       <= '0;
            fb_valid_q <= '0;
            err_q      <= '0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (ret_way[w]) begin
                    fb_q[w] <= fb_d[w];
                end
            end
            fb_valid_q <= ret_way;
            err_q      <= err_q | {overflow, seq_err | underflow};
        end
    end

    // Flatten the registered feedback onto the output buses.
    always_comb begin
        fb_actual_o     = '0;
        fb_conf_o       = '0;
        fb_index_o      = '0;
        fb_tag_o        = '0;
        fb_useful_o     = '0;
        fb_bank_o       = '0;
        fb_mispredict_o = '0;
        for (int w = 0; w < 2; w++) begin
            fb_actual_o[w*32 +: 32]                  = fb_q[w].actual;
            fb_conf_o[w*LP_CW +: LP_CW]              = fb_q[w].conf;
            fb_index_o[w*LP_IDX_W +: LP_IDX_W]       = fb_q[w].index;
            fb_tag_o[w*P_TAG_WIDTH +: P_TAG_WIDTH]   = fb_q[w].tag;
            fb_useful_o[w*P_U_WIDTH +: P_U_WIDTH]    = fb_q[w].useful;
            fb_bank_o[w*P_NUM_BANK +: P_NUM_BANK]    = fb_q[w].bank;
            fb_mispredict_o[w]                       = fb_q[w].mispredict;
        end
        fb_valid_o = fb_valid_q;
        err_o      = err_q;
    end

endmodule
